keypad_scanner: RTL and testbench

- 4x4 matrix keypad scanner and debouncer for the lock's keypad.
- Drives keypad columns and samples the rows.
- Produces the key_valid / key_code pair consumed by the setup and unlock FSMs.
- key_valid is a level: high while a debounced key is held. Consumers do their own rising-edge detection.
- Code 0xF ('#') is the SEND key.

---
 rtl/keypad_scanner_if.sv | 12 +
 rtl/keypad_scanner.sv | 206 ++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scanner_if.sv
// Keypad-side bundle for the scanner: column drive, row sense and the
// debounced key_valid/key_code pair. The scanner uses the master modport;
// the keypad/consumer side uses the slave modport.
interface keypad_scanner_if;
   logic [3:0] row_n;
   logic [3:0] col_n;
   logic       key_valid;
   logic [3:0] key_code;

   modport master (input row_n, output col_n, output key_valid, output key_code);
   modport slave  (output row_n, input col_n, input key_valid, input key_code);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner and debouncer.
// Walks the columns (one driven low at a time), samples the synchronized rows
// at the end of each column slot, debounces press and release, and presents
// key_valid as a level while a key is held.
// Optional feature macro: KEYPAD_REPEAT_EN adds auto-repeat, a one-cycle
// key_valid low pulse after REPEAT_DELAY hold cycles and every REPEAT_PERIOD
// thereafter.
module keypad_scanner #(
   parameter int SCAN_DIV        = 1000,
   parameter int DEBOUNCE_CYCLES = 20000
`ifdef KEYPAD_REPEAT_EN
   ,
   parameter int REPEAT_DELAY    = 5000000,
   parameter int REPEAT_PERIOD   = 1000000
`endif
) (
   input  logic                clk,
   input  logic                rst,
   keypad_scanner_if.master    kp
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int DEB_W = $clog2(DEBOUNCE_CYCLES);

   typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_RELEASE} state_t;

   state_t           state_q, state_d;
   logic [3:0]       row_meta_q, row_s_q;
   logic [1:0]       idx_q, idx_d;
   logic [1:0]       cand_row_q, cand_row_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [DEB_W-1:0] deb_q, deb_d;
   logic             key_valid_q, key_valid_d;
   logic [3:0]       key_code_q, key_code_d;
   logic             row_up;

`ifdef KEYPAD_REPEAT_EN
   localparam int HOLD_W = $clog2(REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD);
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              rep_q, rep_d;
   logic [HOLD_W-1:0] hold_lim;
   assign hold_lim = rep_q ? HOLD_W'(REPEAT_PERIOD - 1) : HOLD_W'(REPEAT_DELAY - 1);
`endif

   // Lowest-index low row wins when several rows in one column are pressed.
   function automatic logic [1:0] low_row(input logic [3:0] r);
      if (!r[0])      return 2'd0;
      else if (!r[1]) return 2'd1;
      else if (!r[2]) return 2'd2;
      else            return 2'd3;
   endfunction

   function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
      case ({r, c})
         4'h0: return 4'h1;  4'h1: return 4'h2;  4'h2: return 4'h3;  4'h3: return 4'hA;
         4'h4: return 4'h4;  4'h5: return 4'h5;  4'h6: return 4'h6;  4'h7: return 4'hB;
         4'h8: return 4'h7;  4'h9: return 4'h8;  4'hA: return 4'h9;  4'hB: return 4'hC;
         4'hC: return 4'hE;  4'hD: return 4'h0;  4'hE: return 4'hF;  default: return 4'hD;
      endcase
   endfunction

   // The column stays frozen while a key is debounced or held, so idx_q is
   // also the candidate column and needs no separate register.
   assign kp.col_n     = ~(4'b0001 << idx_q);
   assign kp.key_valid = key_valid_q;
   assign kp.key_code  = key_code_q;

   // Candidate row has gone high (key released or bounced open).
   assign row_up = row_s_q[cand_row_q];

   // Two-flop synchronizer for the asynchronous row inputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_meta_q <= 4'hF;
         row_s_q    <= 4'hF;
      end else begin
         row_meta_q <= kp.row_n;
         row_s_q    <= row_meta_q;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= SCAN;
         idx_q       <= 2'd0;
         cand_row_q  <= 2'd0;
         div_q       <= '0;
         deb_q       <= '0;
         key_valid_q <= 1'b0;
         key_code_q  <= 4'h0;
`ifdef KEYPAD_REPEAT_EN
         hold_q      <= '0;
         rep_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cand_row_q  <= cand_row_d;
         div_q       <= div_d;
         deb_q       <= deb_d;
         key_valid_q <= key_valid_d;
         key_code_q  <= key_code_d;
`ifdef KEYPAD_REPEAT_EN
         hold_q      <= hold_d;
         rep_q       <= rep_d;
`endif
      end
   end

   // Next-state logic: scan, debounce press, hold, debounce release.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cand_row_d  = cand_row_q;
      div_d       = div_q;
      deb_d       = deb_q;
      key_valid_d = key_valid_q;
      key_code_d  = key_code_q;
`ifdef KEYPAD_REPEAT_EN
      hold_d      = hold_q;
      rep_d       = rep_q;
`endif
      case (state_q)
         SCAN: begin
            key_valid_d = 1'b0;
`ifdef KEYPAD_REPEAT_EN
            hold_d = '0;
            rep_d  = 1'b0;
`endif
            if (div_q == DIV_W'(SCAN_DIV - 1)) begin
               div_d = '0;
               if (row_s_q == 4'hF) begin
                  idx_d = idx_q + 2'd1;
               end else begin
                  cand_row_d = low_row(row_s_q);
                  deb_d      = '0;
                  state_d    = DEB_PRESS;
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         DEB_PRESS: begin
`ifdef KEYPAD_REPEAT_EN
            hold_d = '0;
            rep_d  = 1'b0;
`endif
            if (!row_up) begin
               if (deb_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                  key_code_d  = key_map(cand_row_q, idx_q);
                  key_valid_d = 1'b1;
                  state_d     = HELD;
               end else begin
                  deb_d = deb_q + 1'b1;
               end
            end else begin
               // Bounce or glitch: abandon and move on to the next column.
               state_d = SCAN;
               idx_d   = idx_q + 2'd1;
               div_d   = '0;
            end
         end
         HELD: begin
            key_valid_d = 1'b1;
            if (row_up) begin
               deb_d   = '0;
               state_d = DEB_RELEASE;
            end
`ifdef KEYPAD_REPEAT_EN
            else if (hold_q == hold_lim) begin
               // One-cycle low gives consumers a fresh rising edge.
               key_valid_d = 1'b0;
               hold_d      = '0;
               rep_d       = 1'b1;
            end else begin
               hold_d = hold_q + 1'b1;
            end
`else
            // Without auto-repeat key_valid stays high for the whole hold.
`endif
         end
         DEB_RELEASE: begin
            key_valid_d = 1'b1;
            if (row_up) begin
               if (deb_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                  key_valid_d = 1'b0;
                  state_d     = SCAN;
                  idx_d       = idx_q + 2'd1;
                  div_d       = '0;
               end else begin
                  deb_d = deb_q + 1'b1;
               end
            end else begin
               deb_d   = '0;
               state_d = HELD;
            end
         end
         default: begin
            state_d     = SCAN;
            key_valid_d = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CYCLES=8.
// A behavioural keypad pulls a row low only while the pressed key's column
// is driven. Auto-repeat cases build only with KEYPAD_REPEAT_EN.
module tb_keypad_scanner;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] pressed = '0;   // bit r*4+c
   int          n_chk = 0;
   int          n_pass = 0;
   int          falls = 0;

   keypad_scanner_if kp();

   keypad_scanner #(
      .SCAN_DIV(4),
      .DEBOUNCE_CYCLES(8)
`ifdef KEYPAD_REPEAT_EN
      , .REPEAT_DELAY(40),
      .REPEAT_PERIOD(16)
`endif
   ) dut (
      .clk(clk),
      .rst(rst),
      .kp(kp)
   );

   always #5 clk = ~clk;

   // Keypad matrix model.
   always_comb begin
      kp.row_n = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r*4+c] && !kp.col_n[c]) kp.row_n[r] = 1'b0;
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic wait_kv(input logic lvl, input int lim, output int n);
      n = 0;
      while (kp.key_valid !== lvl && n < lim) begin
         @(negedge clk);
         n++;
      end
   endtask

   // Waits for the first negedge at which column c has just become driven.
   task automatic wait_col(input logic [3:0] c);
      int n;
      n = 0;
      while (kp.col_n == c && n < 40) begin @(negedge clk); n++; end
      while (kp.col_n != c && n < 80) begin @(negedge clk); n++; end
   endtask

   task automatic step(input int cyc);
      logic prev;
      for (int i = 0; i < cyc; i++) begin
         prev = kp.key_valid;
         @(negedge clk);
         if (prev && !kp.key_valid) falls++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int   n;
      logic ok;
      int   bad;

      // Reset state.
      repeat (3) @(negedge clk);
      chk("rst_valid", int'(kp.key_valid), 0);
      chk("rst_code", int'(kp.key_code), 0);
      chk("rst_col", int'(kp.col_n), 'b1110);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("idle_col0_slot", int'(kp.col_n), 'b1110);
      @(negedge clk);
      chk("idle_col1", int'(kp.col_n), 'b1101);

      // Key '5': latency, code, continuous hold, release timing.
      wait_col(4'b1101);
      pressed[1*4+1] = 1'b1;
      wait_kv(1'b1, 30, n);
      chk("k5_rise", int'(kp.key_valid), 1);
      chk("k5_latency", int'(n >= 8 && n <= 14), 1);
      chk("k5_code", int'(kp.key_code), 5);
      ok = 1'b1;
      repeat (50 - n) begin
         @(negedge clk);
         if (!kp.key_valid) ok = 1'b0;
      end
      chk("k5_hold", int'(ok), 1);
      pressed = '0;
      wait_kv(1'b0, 30, n);
      chk("k5_fall_window", int'(n >= 9 && n <= 11), 1);
      chk("k5_code_kept", int'(kp.key_code), 5);

      // '#' held, then '2' pressed on a different column: ignored.
      pressed[3*4+2] = 1'b1;
      wait_kv(1'b1, 60, n);
      chk("hash_rise", int'(kp.key_valid), 1);
      chk("hash_code", int'(kp.key_code), 'hF);
      pressed[0*4+1] = 1'b1;
      ok = 1'b1;
      repeat (30) begin
         @(negedge clk);
         if (!kp.key_valid || kp.key_code != 4'hF) ok = 1'b0;
      end
      chk("hash_ignore_2", int'(ok), 1);
      pressed = '0;
      wait_kv(1'b0, 30, n);
      chk("hash_fall", int'(kp.key_valid), 0);

      // 5-cycle glitch on '7' (row2, col0): debounce aborts to column 1.
      wait_col(4'b1110);
      pressed[2*4+0] = 1'b1;
      ok = 1'b0;
      repeat (5) begin @(negedge clk); if (kp.key_valid) ok = 1'b1; end
      pressed = '0;
      repeat (3) begin @(negedge clk); if (kp.key_valid) ok = 1'b1; end
      chk("glitch_next_col", int'(kp.col_n), 'b1101);
      repeat (40) begin @(negedge clk); if (kp.key_valid) ok = 1'b1; end
      chk("glitch_no_valid", int'(ok), 0);

      // '1' and '4' together: lowest row wins; bouncy release gives one fall.
      pressed[0*4+0] = 1'b1;
      pressed[1*4+0] = 1'b1;
      wait_kv(1'b1, 60, n);
      chk("dual_rise", int'(kp.key_valid), 1);
      chk("dual_code", int'(kp.key_code), 1);
      repeat (5) @(negedge clk);
      falls = 0;
      pressed = '0;
      step(3);
      pressed[0*4+0] = 1'b1;
      pressed[1*4+0] = 1'b1;
      step(2);
      pressed = '0;
      step(40);
      chk("bounce_one_fall", falls, 1);
      chk("bounce_final", int'(kp.key_valid), 0);

      // Reset while 'A' (row0, col3) is held; full re-debounce afterwards.
      pressed[0*4+3] = 1'b1;
      wait_kv(1'b1, 60, n);
      chk("a_code", int'(kp.key_code), 'hA);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_async_valid", int'(kp.key_valid), 0);
      chk("rst_async_col", int'(kp.col_n), 'b1110);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      // Scan reaches col3 at 12, sync+slot sample at 16, debounce 8 more.
      wait_kv(1'b1, 60, n);
      chk("a_rerise_cycles", n, 24);
      chk("a_rerise_code", int'(kp.key_code), 'hA);
      pressed = '0;
      wait_kv(1'b0, 30, n);
      chk("a_fall", int'(kp.key_valid), 0);

`ifdef KEYPAD_REPEAT_EN
      // Hold '9': one-cycle low at hold cycles 40, 56, 72, 88.
      pressed[2*4+2] = 1'b1;
      wait_kv(1'b1, 60, n);
      chk("rep_rise", int'(kp.key_valid), 1);
      bad = 0;
      ok  = 1'b1;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (kp.key_code != 4'h9) ok = 1'b0;
         if (i == 40 || i == 56 || i == 72 || i == 88)
            chk($sformatf("rep_pulse_%0d", i), int'(kp.key_valid), 0);
         else if (!kp.key_valid)
            bad++;
      end
      chk("rep_no_extra_low", bad, 0);
      chk("rep_code_9", int'(ok), 1);
      pressed = '0;
      wait_kv(1'b0, 30, n);
      chk("rep_fall", int'(kp.key_valid), 0);
`else
      bad = 0;
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
